// File: rtl/bcd_countdown_timer_if.sv
// Purpose: bundles the control inputs and the count/display outputs of the BCD countdown timer.
// Latency: none; wiring only.
// Backpressure: none; the timer samples its inputs every cycle.
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  go;
    logic                  hold;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   display;
    logic                  running;
    logic                  time_out;
    logic                  expired;

    // Controller side: drives the commands, observes the timer
    modport master (
        output load, load_value, go, hold,
        input  bcd, display, running, time_out, expired
    );

    // Timer side
    modport slave (
        input  load, load_value, go, hold,
        output bcd, display, running, time_out, expired
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Purpose: multi-digit BCD countdown timer with prescaler, pause/resume and 7-segment decode.
// Latency: commands act on the next clock_50 edge; the count steps every TICK_DIV cycles while running.
// Backpressure: none; load > hold > go each cycle. Optional macro COUNTDOWN_AUTORELOAD_EN reloads on zero.
module bcd_countdown_timer #(
    parameter int DIGITS   = 2,
    parameter int START    = 30,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                 clock_50,
    input  logic                 reset,
    bcd_countdown_timer_if.slave tif
);
    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);

    // Decimal integer to packed BCD, digit 0 in the low nibble
    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Any nibble above 9 becomes 9 so the count is always valid BCD
    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    // Decrement by one digit-wise; a zero digit becomes 9 and borrows from the next
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low segments, bit order g..a
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    localparam logic [CW-1:0] START_BCD = to_bcd(START);
    localparam logic [PW-1:0] P_LAST    = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   presc;
    logic            expired_q;
    logic [CW-1:0]   count_dec;
    logic [7*DIGITS-1:0] disp;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [CW-1:0]   reload_val;
`endif

    assign count_dec = bcd_dec(count);

    // Timer FSM: load overrides everything, hold beats go, prescaler only moves in RUN
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= START_BCD;
            presc      <= '0;
            expired_q  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_val <= START_BCD;
`endif
        end else begin
            expired_q <= 1'b0;
            if (tif.load) begin
                count <= bcd_clamp(tif.load_value);
                presc <= '0;
                state <= IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
                reload_val <= bcd_clamp(tif.load_value);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (!tif.hold && tif.go) begin
                            if (count == '0) begin
                                state     <= DONE;
                                expired_q <= 1'b1;
                            end else begin
                                state <= RUN;
                                presc <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (tif.hold) begin
                            // Prescaler is frozen, so a coincident tick is dropped
                            state <= PAUSE;
                        end else if (presc == P_LAST) begin
                            presc <= '0;
                            if (count_dec == '0) begin
                                expired_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                count <= reload_val;
`else
                                count <= count_dec;
                                state <= DONE;
`endif
                            end else begin
                                count <= count_dec;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!tif.hold && tif.go)
                            state <= RUN;
                    end
                    default: ;  // DONE waits for load or reset
                endcase
            end
        end
    end

    // Per-digit 7-segment decode straight from the count
    always_comb begin
        disp = '0;
        for (int i = 0; i < DIGITS; i++)
            disp[7*i +: 7] = seg7(count[4*i +: 4]);
    end

    assign tif.bcd     = count;
    assign tif.display = disp;
    assign tif.running = (state == RUN);
    assign tif.expired = expired_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    assign tif.time_out = (state == DONE) || expired_q;
`else
    assign tif.time_out = (state == DONE);
`endif
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Purpose: directed self-checking bench for bcd_countdown_timer (DIGITS=2, START=30, TICK_DIV=4).
// Latency: checks sample 1 ns after each rising edge, inputs change at the same point.
// Backpressure: none; fixed-length stimulus, always reaches the summary line.
module tb_bcd_countdown_timer;
    localparam int DIGITS   = 2;
    localparam int START    = 30;
    localparam int TICK_DIV = 4;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG3 = 7'b0110000;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG9 = 7'b0010000;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    int   run_seen = 0;

    bcd_countdown_timer_if #(.DIGITS(DIGITS)) tif ();

    bcd_countdown_timer #(
        .DIGITS  (DIGITS),
        .START   (START),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clock_50(clock_50),
        .reset   (reset),
        .tif     (tif)
    );

    always #5 clock_50 = ~clock_50;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    function automatic logic [7:0] d2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        tif.load       = 1'b0;
        tif.load_value = '0;
        tif.go         = 1'b0;
        tif.hold       = 1'b0;

        // Reset state
        step(2);
        chk("rst_bcd", tif.bcd, 8'h30);
        chk("rst_running", tif.running, 1'b0);
        chk("rst_time_out", tif.time_out, 1'b0);
        chk("rst_expired", tif.expired, 1'b0);
        chk("rst_display", tif.display, {SEG3, SEG0});
        reset = 1'b0;
        step(1);
        chk("idle_bcd", tif.bcd, 8'h30);
        chk("idle_running", tif.running, 1'b0);

        // Full countdown from 30: one step every 4 cycles
        tif.go = 1'b1;
        step(1);
        tif.go = 1'b0;
        chk("run_start", tif.running, 1'b1);
        chk("run_start_bcd", tif.bcd, 8'h30);
        for (int k = 1; k < 120; k++) begin
            step(1);
            chk("countdown", tif.bcd, {56'd0, d2b(30 - k / 4)});
            if (tif.expired) pulses++;
        end
        step(1);
`ifdef COUNTDOWN_AUTORELOAD_EN
        chk("ar_wrap_bcd", tif.bcd, 8'h30);
        chk("ar_wrap_running", tif.running, 1'b1);
        chk("ar_wrap_expired", tif.expired, 1'b1);
        chk("ar_wrap_time_out", tif.time_out, 1'b1);
        step(1);
        chk("ar_wrap_expired_low", tif.expired, 1'b0);
`else
        chk("done_bcd", tif.bcd, 8'h00);
        chk("done_time_out", tif.time_out, 1'b1);
        chk("done_running", tif.running, 1'b0);
        chk("done_display", tif.display, {SEG0, SEG0});
        if (tif.expired) pulses++;
        // go and hold have no effect in DONE
        tif.go = 1'b1;
        step(2);
        tif.go   = 1'b0;
        tif.hold = 1'b1;
        step(1);
        tif.hold = 1'b0;
        if (tif.expired) pulses++;
        chk("expired_once", pulses, 1);
        chk("done_sticky", tif.time_out, 1'b1);
        chk("done_no_wrap", tif.bcd, 8'h00);
`endif

        // Pause and resume from 10
        tif.load       = 1'b1;
        tif.load_value = 8'h10;
        step(1);
        tif.load = 1'b0;
        chk("load10_bcd", tif.bcd, 8'h10);
        chk("load10_idle", tif.running, 1'b0);
        chk("load10_time_out", tif.time_out, 1'b0);
        tif.go = 1'b1;
        step(1);
        tif.go = 1'b0;
        step(6);
        chk("pre_hold_bcd", tif.bcd, 8'h09);
        tif.hold = 1'b1;
        step(1);
        chk("paused_running", tif.running, 1'b0);
        step(19);
        chk("paused_bcd", tif.bcd, 8'h09);
        chk("paused_still", tif.running, 1'b0);
        tif.hold = 1'b0;
        tif.go   = 1'b1;
        step(1);
        tif.go = 1'b0;
        chk("resume_running", tif.running, 1'b1);
        step(1);
        chk("resume_plus1", tif.bcd, 8'h09);
        step(1);
        chk("resume_plus2", tif.bcd, 8'h08);

        // Go with a zero count goes straight to DONE
        tif.load       = 1'b1;
        tif.load_value = 8'h00;
        step(1);
        tif.load = 1'b0;
        chk("zero_idle", tif.time_out, 1'b0);
        tif.go = 1'b1;
        step(1);
        tif.go = 1'b0;
        if (tif.running) run_seen++;
        chk("zero_time_out", tif.time_out, 1'b1);
        chk("zero_expired", tif.expired, 1'b1);
        step(1);
        if (tif.running) run_seen++;
        chk("zero_expired_low", tif.expired, 1'b0);
        chk("zero_done", tif.time_out, 1'b1);
        chk("zero_never_run", run_seen, 0);

        // Clamp of invalid digits, load beating go, hold beating go
        tif.load       = 1'b1;
        tif.load_value = 8'hA5;
        step(1);
        chk("clamp_bcd", tif.bcd, 8'h95);
        chk("clamp_display", tif.display, {SEG9, SEG5});
        tif.load_value = 8'h42;
        tif.go         = 1'b1;
        step(1);
        tif.load = 1'b0;
        tif.go   = 1'b0;
        chk("load_go_bcd", tif.bcd, 8'h42);
        chk("load_go_idle", tif.running, 1'b0);
        step(1);
        chk("load_go_stays", tif.running, 1'b0);
        tif.hold = 1'b1;
        tif.go   = 1'b1;
        step(1);
        tif.hold = 1'b0;
        tif.go   = 1'b0;
        chk("hold_go_idle", tif.running, 1'b0);

        // Asynchronous reset mid-run at 17
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tif.go = 1'b1;
        step(1);
        tif.go = 1'b0;
        step(52);
        chk("pre_reset_bcd", tif.bcd, 8'h17);
        chk("pre_reset_run", tif.running, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_bcd", tif.bcd, 8'h30);
        chk("async_rst_idle", tif.running, 1'b0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("post_rst_idle", tif.running, 1'b0);
        tif.go = 1'b1;
        step(1);
        tif.go = 1'b0;
        step(3);
        chk("post_rst_no_early_tick", tif.bcd, 8'h30);
        step(1);
        chk("post_rst_first_tick", tif.bcd, 8'h29);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload from 02
        tif.load       = 1'b1;
        tif.load_value = 8'h02;
        step(1);
        tif.load = 1'b0;
        tif.go   = 1'b1;
        step(1);
        tif.go = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step(4);
            chk("ar_bcd", tif.bcd, (t % 2 == 1) ? 8'h01 : 8'h02);
            chk("ar_expired", tif.expired, (t % 2 == 0) ? 1'b1 : 1'b0);
            chk("ar_running", tif.running, 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: DIGITS, default 2, number of BCD digits (1..8).
REQ-002 Parameter: START, default 30, decimal reset/preset value, SHALL be < 10^DIGITS.
REQ-003 Parameter: TICK_DIV, default 50_000_000, clock_50 cycles per count step (>= 2).
REQ-004 Port: clock_50  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: load  input  1  synchronous; loads load_value and returns to IDLE.
REQ-007 Port: load_value  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
REQ-008 Port: go  input  1  start from IDLE, resume from PAUSE.
REQ-009 Port: hold  input  1  pause while RUN.
REQ-010 Port: bcd  output  4*DIGITS  current count, BCD, digit 0 least significant.
REQ-011 Port: display  output  7*DIGITS  active-low 7-segment pattern per digit (0 = 1000000, 9 = 0010000); digit 0 in bits [6:0].
REQ-012 Port: running  output  1  high in RUN.
REQ-013 Port: time_out  output  1  high in DONE (count is zero).
REQ-014 Port: expired  output  1  one-cycle pulse on the cycle DONE is entered.

Function
REQ-015 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-016 Input priority per cycle: load > hold > go.
REQ-017 load in any state: count <= load_value (any digit > 9 clamped to 9), prescaler <= 0, state <= IDLE, expired <= 0.
REQ-018 IDLE + go: count nonzero -> RUN, prescaler <= 0; count zero -> DONE with expired pulse.
REQ-019 RUN + hold -> PAUSE, prescaler value retained; PAUSE + go (hold low) -> RUN, prescaler resumes from retained value.
REQ-020 Prescaler SHALL advance only in RUN, wrapping TICK_DIV-1 -> 0; the wrap cycle is the tick.
REQ-021 On tick, count SHALL decrement by 1 in BCD (digit 0 -> 9 with borrow into next digit); no binary intermediate visible on bcd.
REQ-022 Tick taking count 1 -> 0: state <= DONE, expired high for that following cycle only.
REQ-023 Tick and hold in the same cycle: hold wins, no decrement.
REQ-024 DONE SHALL be held until load or reset; go and hold ignored in DONE; count never wraps below 0.
REQ-025 display SHALL be combinational from bcd; code > 9 SHALL show 1111111.
REQ-026 time_out and running SHALL be decoded from state (no extra latency beyond the state register).

Reset
REQ-027 reset high SHALL immediately force: count = START in BCD, state IDLE, prescaler 0, running 0, time_out 0, expired 0.
REQ-028 reset asserted mid-RUN SHALL discard the partial prescaler; release resumes in IDLE.

Configuration
REQ-029 Macro COUNTDOWN_AUTORELOAD_EN: when defined, a tick taking count to 0 SHALL pulse expired, reload the last loaded value (START after reset) and remain in RUN; time_out SHALL pulse with expired and DONE is never entered from RUN.
REQ-030 Without COUNTDOWN_AUTORELOAD_EN, behaviour is REQ-022/REQ-024 exactly.

Verification (TICK_DIV=4, DIGITS=2, START=30 unless noted)
REQ-031 Reset, go for 1 cycle, run 4*30 cycles -> bcd 30,29,...,20,19,...,01,00; time_out high; expired high exactly one cycle; display 1000000 1000000.
REQ-032 Load 8'h10, go, hold after 6 cycles for 20 cycles, release, go -> bcd 10, 09 held through pause, 08 reached 2 cycles after resume.
REQ-033 Load 8'h00, go -> DONE next cycle, expired one pulse, running never high.
REQ-034 Load 8'hA5 -> bcd 95; load and go asserted together -> stays IDLE.
REQ-035 Assert reset asynchronously mid-RUN at count 17 -> bcd 30, state IDLE before next clock edge.
REQ-036 With COUNTDOWN_AUTORELOAD_EN, load 8'h02, go -> 02,01,02,01,... with expired pulse each reload, running stays high.
